// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
package pll_seq_pkg;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAIL      = 2'd3
    } seq_state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_STABLE    = 1024;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_MAX_RETRY      = 3;

    // Width of the retry counter: must hold 0..max_retry inclusive.
    function automatic int retry_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// PLL-side and system-side signals of the reset/lock sequencer.
// master = the sequencer, slave = the PLL wrapper / system it controls.
interface pll_reset_seq_if #(
    parameter int RW = 2
);
    logic          locked;
    logic          clear_flags;
    logic          pll_reset;
    logic          pll_bypass;
    logic          sys_reset_n;
    logic          pll_ok;
    logic          pll_failed;
    logic          lock_lost;
    logic [RW-1:0] retry_count;
    logic [1:0]    state_dbg;

    modport master (
        input  locked, clear_flags,
        output pll_reset, pll_bypass, sys_reset_n, pll_ok, pll_failed,
               lock_lost, retry_count, state_dbg
    );

    modport slave (
        output locked, clear_flags,
        input  pll_reset, pll_bypass, sys_reset_n, pll_ok, pll_failed,
               lock_lost, retry_count, state_dbg
    );
endinterface

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for slow asynchronous status inputs, with a
// synchronous active-low clear that returns both stages to 0.
module sync_ff2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Shift the async input through two stages to settle metastability.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable
// lock, then releases the system reset. Failed locks are retried; after
// MAX_RETRY failures the PLL is bypassed and held in reset for good.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic            clk_in,
    input  logic            reset_n,
    pll_reset_seq_if.master bus
);
    localparam int RW   = retry_w(MAX_RETRY);
    localparam int TMAX = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int SW   = $clog2(LOCK_STABLE + 1);

    localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          lock_lost_q, lock_lost_d;
    logic          pll_reset_q, pll_reset_d;
    logic          pll_bypass_q, pll_bypass_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          pll_ok_q, pll_ok_d;
    logic          pll_failed_q, pll_failed_d;
    logic          loss_evt;
    logic          locked_s;

    sync_ff2 u_lock_sync (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .d_i    (bus.locked),
        .q_o    (locked_s)
    );

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        stab_d   = stab_q;
        retry_d  = retry_q;
        loss_evt = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                stab_d = '0;
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                timer_d = (timer_q == WAIT_LAST) ? timer_q : timer_q + 1'b1;
                if (locked_s) begin
                    stab_d = (stab_q == STAB_LAST) ? stab_q : stab_q + 1'b1;
                end else begin
                    stab_d = '0;
                end
                // A lock completing on the timeout cycle still counts as success.
                if (locked_s && (stab_q == STAB_LAST)) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    stab_d  = '0;
                    retry_d = '0;
                end else if (timer_q == WAIT_LAST) begin
                    timer_d = '0;
                    stab_d  = '0;
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end
            end
            ST_RUN: begin
                // Any synchronised low restarts a fresh attempt series.
                if (!locked_s) begin
                    state_d  = ST_RESET_PLL;
                    timer_d  = '0;
                    retry_d  = '0;
                    loss_evt = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        pll_reset_d  = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        pll_bypass_d = (state_d == ST_FAIL);
        pll_ok_d     = (state_d == ST_RUN);
        pll_failed_d = (state_d == ST_FAIL);
        // Release lags state entry by one cycle; assertion on lock loss is immediate.
        sys_rst_n_d  = ((state_q == ST_RUN) && (state_d == ST_RUN)) || (state_q == ST_FAIL);
        // A loss in the same cycle as a clear keeps the flag set.
        lock_lost_d  = loss_evt ? 1'b1 : (bus.clear_flags ? 1'b0 : lock_lost_q);
    end

    // State, counters and outputs; reset returns everything to RESET_PLL.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q      <= ST_RESET_PLL;
            timer_q      <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            lock_lost_q  <= 1'b0;
            pll_reset_q  <= 1'b1;
            pll_bypass_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            pll_ok_q     <= 1'b0;
            pll_failed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            lock_lost_q  <= lock_lost_d;
            pll_reset_q  <= pll_reset_d;
            pll_bypass_q <= pll_bypass_d;
            sys_rst_n_q  <= sys_rst_n_d;
            pll_ok_q     <= pll_ok_d;
            pll_failed_q <= pll_failed_d;
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.pll_bypass  = pll_bypass_q;
    assign bus.sys_reset_n = sys_rst_n_q;
    assign bus.pll_ok      = pll_ok_q;
    assign bus.pll_failed  = pll_failed_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq. Instance A uses the small test
// parameters, B the same with a long timeout (chatter), C the defaults.
// Cycle index cyc counts edges since the last edge that sampled reset_n=0.
module tb_pll_reset_seq;
    import pll_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pll_reset_seq_if #(.RW(retry_w(2))) if_a ();
    pll_reset_seq_if #(.RW(retry_w(2))) if_b ();
    pll_reset_seq_if #(.RW(retry_w(DEF_MAX_RETRY))) if_c ();

    pll_reset_seq #(.PLL_RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2)) dut_a (
        .clk_in (clk), .reset_n (reset_n), .bus (if_a.master));
    pll_reset_seq #(.PLL_RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(128), .MAX_RETRY(2)) dut_b (
        .clk_in (clk), .reset_n (reset_n), .bus (if_b.master));
    pll_reset_seq dut_c (
        .clk_in (clk), .reset_n (reset_n), .bus (if_c.master));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_reset_a(input string pfx);
        chk_eq({pfx, "_state"},     32'(if_a.state_dbg),   32'd0);
        chk_eq({pfx, "_pll_reset"}, 32'(if_a.pll_reset),   32'd1);
        chk_eq({pfx, "_bypass"},    32'(if_a.pll_bypass),  32'd0);
        chk_eq({pfx, "_sys_rst_n"}, 32'(if_a.sys_reset_n), 32'd0);
        chk_eq({pfx, "_pll_ok"},    32'(if_a.pll_ok),      32'd0);
        chk_eq({pfx, "_failed"},    32'(if_a.pll_failed),  32'd0);
        chk_eq({pfx, "_lock_lost"}, 32'(if_a.lock_lost),   32'd0);
        chk_eq({pfx, "_retry"},     32'(if_a.retry_count), 32'd0);
    endtask

    initial begin
        int hi;
        int bad;
        reset_n = 1'b0;
        if_a.locked = 1'b0; if_a.clear_flags = 1'b0;
        if_b.locked = 1'b0; if_b.clear_flags = 1'b0;
        if_c.locked = 1'b0; if_c.clear_flags = 1'b0;

        // ---- Normal lock on A: locked high from cycle 10 ----
        do_reset();
        chk_reset_a("por");
        hi = 0;
        while (cyc < 4) begin
            if (if_a.pll_reset) hi++;
            step();
        end
        chk_eq("pllrst_len",  32'(hi),             32'd4);
        chk_eq("pllrst_off",  32'(if_a.pll_reset), 32'd0);
        chk_eq("wait_state",  32'(if_a.state_dbg), 32'd1);
        wait_to(10);
        if_a.locked = 1'b1;
        wait_to(20);
        chk_eq("run_state",     32'(if_a.state_dbg),   32'd2);
        chk_eq("run_pll_ok",    32'(if_a.pll_ok),      32'd1);
        chk_eq("run_sys_lag",   32'(if_a.sys_reset_n), 32'd0);
        step();
        chk_eq("run_sys_rel",   32'(if_a.sys_reset_n), 32'd1);
        chk_eq("run_retry",     32'(if_a.retry_count), 32'd0);

        // ---- Lock loss: one low cycle at 30 ----
        wait_to(30);
        if_a.locked = 1'b0;
        step();
        if_a.locked = 1'b1;
        step();
        chk_eq("loss_still_run", 32'(if_a.sys_reset_n), 32'd1);
        step();
        chk_eq("loss_state",     32'(if_a.state_dbg),   32'd0);
        chk_eq("loss_sys",       32'(if_a.sys_reset_n), 32'd0);
        chk_eq("loss_ok",        32'(if_a.pll_ok),      32'd0);
        chk_eq("loss_flag",      32'(if_a.lock_lost),   32'd1);
        chk_eq("loss_retry",     32'(if_a.retry_count), 32'd0);
        chk_eq("loss_pll_reset", 32'(if_a.pll_reset),   32'd1);
        wait_to(45);
        chk_eq("relock_state",   32'(if_a.state_dbg),   32'd2);
        chk_eq("relock_flag",    32'(if_a.lock_lost),   32'd1);
        step();
        chk_eq("relock_sys",     32'(if_a.sys_reset_n), 32'd1);
        wait_to(50);
        chk_eq("pre_clear_flag", 32'(if_a.lock_lost),   32'd1);
        if_a.clear_flags = 1'b1;
        step();
        if_a.clear_flags = 1'b0;
        chk_eq("cleared_flag",   32'(if_a.lock_lost),   32'd0);

        // ---- Loss coinciding with clear, then locked held low ----
        wait_to(60);
        if_a.locked = 1'b0;
        wait_to(62);
        if_a.clear_flags = 1'b1;
        step();
        if_a.clear_flags = 1'b0;
        chk_eq("simul_flag",  32'(if_a.lock_lost), 32'd1);
        chk_eq("simul_state", 32'(if_a.state_dbg), 32'd0);

        // ---- Retry then fail: attempts start at 63 and 99 ----
        hi = 0;
        while (cyc < 135) begin
            if (if_a.pll_reset) hi++;
            if (cyc == 98)  chk_eq("retry0_before", 32'(if_a.retry_count), 32'd0);
            if (cyc == 99)  chk_eq("retry1",        32'(if_a.retry_count), 32'd1);
            if (cyc == 103) chk_eq("retry1_wait",   32'(if_a.state_dbg),   32'd1);
            step();
        end
        chk_eq("retry_pllrst_cycles", 32'(hi),               32'd8);
        chk_eq("fail_state",          32'(if_a.state_dbg),   32'd3);
        chk_eq("fail_retry",          32'(if_a.retry_count), 32'd2);
        chk_eq("fail_failed",         32'(if_a.pll_failed),  32'd1);
        chk_eq("fail_bypass",         32'(if_a.pll_bypass),  32'd1);
        chk_eq("fail_pll_reset",      32'(if_a.pll_reset),   32'd1);
        chk_eq("fail_sys_lag",        32'(if_a.sys_reset_n), 32'd0);
        chk_eq("fail_flag_kept",      32'(if_a.lock_lost),   32'd1);
        step();
        chk_eq("fail_sys",            32'(if_a.sys_reset_n), 32'd1);
        bad = 0;
        repeat (200) begin
            step();
            if (if_a.state_dbg != 2'd3 || !if_a.pll_bypass || !if_a.pll_reset ||
                !if_a.pll_failed || !if_a.sys_reset_n || if_a.retry_count != 2'd2) bad++;
        end
        chk_eq("fail_hold_bad_cycles", 32'(bad), 32'd0);

        // ---- Reset while in FAIL ----
        reset_n = 1'b0;
        step();
        chk_reset_a("fail_rst");

        // ---- Reset during second WAIT_LOCK at timer 20 ----
        if_a.locked = 1'b0;
        do_reset();
        wait_to(60);
        chk_eq("wait2_retry", 32'(if_a.retry_count), 32'd1);
        chk_eq("wait2_state", 32'(if_a.state_dbg),   32'd1);
        reset_n = 1'b0;
        step();
        chk_reset_a("wait_rst");

        // ---- Chatter on B: 5 high / 1 low for 30 cycles, then high ----
        do_reset();
        bad = 0;
        while (cyc < 40) begin
            if (if_b.sys_reset_n || if_b.state_dbg == 2'd2) bad++;
            if_b.locked = (cyc >= 30) || ((cyc % 6) != 5);
            step();
        end
        chk_eq("chatter_early", 32'(bad),              32'd0);
        chk_eq("chatter_run",   32'(if_b.state_dbg),   32'd2);
        chk_eq("chatter_sys0",  32'(if_b.sys_reset_n), 32'd0);
        step();
        chk_eq("chatter_sys1",  32'(if_b.sys_reset_n), 32'd1);

        // ---- Defaults on C: locked from cycle 100 ----
        do_reset();
        wait_to(100);
        if_c.locked = 1'b1;
        wait_to(1126);
        chk_eq("dflt_state",  32'(if_c.state_dbg),   32'd2);
        chk_eq("dflt_sys0",   32'(if_c.sys_reset_n), 32'd0);
        step();
        chk_eq("dflt_sys1",   32'(if_c.sys_reset_n), 32'd1);
        chk_eq("dflt_ok",     32'(if_c.pll_ok),      32'd1);
        chk_eq("dflt_retry",  32'(if_c.retry_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset/lock sequencer that sits directly upstream and downstream of the iCE40 PLL wrapper.
- Clocked by the 25 MHz reference clock; it drives the PLL's reset and bypass inputs and consumes its `locked` output.
- Issues the system reset only after lock has been stable. It retries failed locks and falls back to bypass (reference clock passthrough) after repeated failure.
- `sys_reset_n` is synchronous to `clk_in`; consumer clock domains apply their own synchroniser.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_reset` is held high per attempt (>=2).
- LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release (>=1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK per attempt (> LOCK_STABLE).
- MAX_RETRY, 3, failed attempts before entering FAIL (>=1).

Ports:
- clk_in  in  1  reference clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- locked  in  1  PLL lock status; asynchronous to clk_in.
- clear_flags  in  1  one-cycle pulse; clears `lock_lost`.
- pll_reset  out  1  to PLL reset (active-high).
- pll_bypass  out  1  to PLL bypass.
- sys_reset_n  out  1  system reset, active-low.
- pll_ok  out  1  high in RUN.
- pll_failed  out  1  high in FAIL.
- lock_lost  out  1  sticky; lock dropped while in RUN.
- retry_count  out  RW  failed attempts in current series; RW = $clog2(MAX_RETRY+1).
- state_dbg  out  2  encoded current state.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state = RESET_PLL, all counters 0.
  - pll_reset=1, pll_bypass=0, sys_reset_n=0, pll_ok=0, pll_failed=0, lock_lost=0, retry_count=0.
  - Sync flops cleared to 0.
  - Reset mid-operation from any state behaves identically.
- Synchronisation: `locked` passes through 2 flops to give locked_s. Input-to-locked_s latency is 2 cycles. No other use of raw `locked`.
- All outputs are registered. Encoding: RESET_PLL=0, WAIT_LOCK=1, RUN=2, FAIL=3.
- RESET_PLL:
  - pll_reset=1, sys_reset_n=0.
  - Timer counts 0..PLL_RST_CYCLES-1, then the state goes to WAIT_LOCK with timer=0 and stable count=0.
  - pll_reset is high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_reset=0, sys_reset_n=0. Timer increments each cycle.
  - Stable counter increments while locked_s=1 and returns to 0 on any locked_s=0.
  - Stable counter reaching LOCK_STABLE (i.e. the LOCK_STABLE-th consecutive high) -> RUN. Success wins over a timeout in the same cycle.
  - Otherwise timer reaching LOCK_TIMEOUT-1 -> retry_count+1.
    - New count == MAX_RETRY -> FAIL.
    - Else -> RESET_PLL.
- RUN:
  - sys_reset_n=1, pll_ok=1, retry_count cleared to 0 on entry.
  - locked_s=0 for any single cycle causes, on the next edge: state RESET_PLL, sys_reset_n=0, pll_ok=0, lock_lost=1, retry_count=0 (fresh series).
  - No glitch filtering beyond the synchroniser.
- FAIL:
  - pll_bypass=1, pll_reset=1 (PLL held in reset), pll_failed=1.
  - sys_reset_n=1 from the cycle after entry; the system runs on the bypassed reference clock.
  - Terminal until reset_n.
  - retry_count holds MAX_RETRY.
- lock_lost:
  - Set only by the RUN loss event; cleared by clear_flags.
  - Set and clear in the same cycle -> remains set.
  - Unaffected by FAIL.
- Counters are sized by $clog2 of their limits and saturate at their compare value; no wrap is reachable.

Decomposition:
- Shared package pll_seq_pkg:
  - State enum (2-bit, values above).
  - Default parameter constants.
  - Width helper for retry_count.
- One sub-module, sync_ff2: parameterless 2-flop synchroniser with synchronous active-low clear. It is reused elsewhere for async status inputs.
- Sequencer FSM, timer and stable counter stay in pll_reset_seq.

Test Plan:
(PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2 unless stated.)
- Normal lock: release reset_n; drive locked=1 from cycle 10 -> pll_reset high cycles 1-4. sys_reset_n rises at locked-rise +2 (sync) +8 (stable) +1 (registered output); pll_ok=1, retry_count=0.
- Chatter: locked toggles high 5 cycles / low 1 repeatedly for 30 cycles, then stays high -> no release during chatter; RUN reached exactly 8 synced-high cycles after the final rise.
- Retry then fail: locked held 0 -> pll_reset pulses twice (4 cycles each); retry_count goes 1 then 2 -> FAIL. pll_bypass=1, pll_reset=1, pll_failed=1, sys_reset_n=1; stays so for 200 cycles.
- Lock loss: in RUN, drop locked for 1 cycle -> 3 cycles later sys_reset_n=0, lock_lost=1, state RESET_PLL; relock returns to RUN with lock_lost still 1. clear_flags pulse -> 0. Simultaneous clear and loss -> lock_lost=1.
- Reset mid-operation: assert reset_n=0 during WAIT_LOCK timer=20 and during FAIL -> next edge all outputs at reset values, retry_count=0, pll_bypass=0.
- Defaults: default parameters, locked=1 after 100 cycles -> sys_reset_n rises at cycle 100+2+1024+1 from release, ±0.
